// File: rtl/dem_dac_pkg.sv
// Shared widths, quantizer limits and sample/accumulator types for the DSM -> DEM DAC path.
package dem_dac_pkg;

    localparam int INPUT_WIDTH = 16;
    localparam int QUANT_BITS  = 5;
    localparam int SHIFT       = INPUT_WIDTH - QUANT_BITS;
    localparam int ACC_WIDTH   = INPUT_WIDTH + 3;

    localparam int QMAX = (2 ** (QUANT_BITS - 1)) - 1;
    localparam int QMIN = -(2 ** (QUANT_BITS - 1));

    // Residual error is held to half a quantizer step so the loop cannot run away.
    localparam int EMAX = (2 ** (SHIFT - 1)) - 1;
    localparam int EMIN = -(2 ** (SHIFT - 1));

    typedef logic signed [INPUT_WIDTH-1:0] sample_t;
    typedef logic signed [ACC_WIDTH-1:0]   acc_t;
    typedef logic signed [QUANT_BITS-1:0]  q_t;

endpackage

// File: rtl/dsm_quantizer.sv
// Combinational requantizer: round-half-up to QUANT_BITS levels, clamp, saturate residual error.
module dsm_quantizer
    import dem_dac_pkg::*;
(
    input  acc_t y,
    output q_t   q,
    output acc_t e,
    output logic ovf
);

    localparam acc_t HALF_LSB = acc_t'(2 ** (SHIFT - 1));
    localparam acc_t Q_HI     = acc_t'(QMAX);
    localparam acc_t Q_LO     = acc_t'(QMIN);
    localparam acc_t E_HI     = acc_t'(EMAX);
    localparam acc_t E_LO     = acc_t'(EMIN);

    function automatic acc_t round_shift(input acc_t v);
        return (v + HALF_LSB) >>> SHIFT;
    endfunction

    function automatic acc_t sat_err(input acc_t v);
        if (v > E_HI)
            return E_HI;
        else if (v < E_LO)
            return E_LO;
        else
            return v;
    endfunction

    acc_t q_raw;
    acc_t q_wide;

    always_comb begin
        q_raw = round_shift(y);
        ovf   = 1'b0;
        q     = q_t'(q_raw);
        if (q_raw > Q_HI) begin
            q   = q_t'(QMAX);
            ovf = 1'b1;
        end else if (q_raw < Q_LO) begin
            q   = q_t'(QMIN);
            ovf = 1'b1;
        end
        q_wide = acc_t'(q) <<< SHIFT;
        e      = sat_err(y - q_wide);
    end

endmodule

// File: rtl/dsm_modulator.sv
// Second-order error-feedback delta-sigma modulator with valid/ready on both sides
// and a single output register stage feeding the DEM.
module dsm_modulator
    import dem_dac_pkg::*;
(
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          clear_i,
    input  logic signed [INPUT_WIDTH-1:0] in_data_i,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    output logic signed [INPUT_WIDTH-1:0] code_o,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic                          overload_o
);

    acc_t    e1_p1;
    acc_t    e2_p1;
    sample_t code_p1;
    logic    vld_p1;
    logic    ovl_p1;

    acc_t    y_p0;
    q_t      q_p0;
    acc_t    e_p0;
    logic    ovf_p0;
    logic    accept;

    assign in_ready_o = !vld_p1 || out_ready_i;
    assign accept     = in_valid_i && in_ready_o;

    // Stage p0: noise-shaping sum and requantization, combinational on the input sample.
    assign y_p0 = acc_t'(in_data_i) + (e1_p1 <<< 1) - e2_p1;

    dsm_quantizer u_quant (
        .y   (y_p0),
        .q   (q_p0),
        .e   (e_p0),
        .ovf (ovf_p0)
    );

    // Stage p1: error history, output code register and sticky overload.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            e1_p1   <= '0;
            e2_p1   <= '0;
            code_p1 <= '0;
            vld_p1  <= 1'b0;
            ovl_p1  <= 1'b0;
        end else if (clear_i) begin
            e1_p1   <= '0;
            e2_p1   <= '0;
            code_p1 <= '0;
            vld_p1  <= 1'b0;
            ovl_p1  <= 1'b0;
        end else if (accept) begin
            e2_p1   <= e1_p1;
            e1_p1   <= e_p0;
            code_p1 <= sample_t'(q_p0);
            vld_p1  <= 1'b1;
            ovl_p1  <= ovl_p1 | ovf_p0;
        end else if (out_ready_i) begin
            vld_p1  <= 1'b0;
        end
    end

    assign code_o      = code_p1;
    assign out_valid_o = vld_p1;
    assign overload_o  = ovl_p1;

endmodule

// File: tb/tb_dsm_modulator.sv
// Scoreboard bench for dsm_modulator: directed samples push hand-computed codes, a monitor pops on transfer.
module tb_dsm_modulator;
    import dem_dac_pkg::*;

    logic    clk = 1'b0;
    logic    reset_n;
    logic    clear;
    sample_t in_data;
    logic    in_valid;
    logic    in_ready;
    sample_t code;
    logic    out_valid;
    logic    out_ready;
    logic    overload;

    int      n_checks = 0;
    int      n_pass   = 0;
    sample_t exp_q[$];
    sample_t mon_exp;

    always #5 clk = ~clk;

    dsm_modulator dut (
        .clk_i       (clk),
        .reset_i     (reset_n),
        .clear_i     (clear),
        .in_data_i   (in_data),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .code_o      (code),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .overload_o  (overload)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Called at a negedge; returns at the negedge after the sample is accepted.
    task automatic send(input int x, input int e);
        bit took;
        int guard;
        took  = 1'b0;
        guard = 0;
        in_data  = sample_t'(x);
        in_valid = 1'b1;
        while (!took && guard < 50) begin
            #1;
            took = in_ready && !clear;
            if (took)
                exp_q.push_back(sample_t'(e));
            @(posedge clk);
            @(negedge clk);
            guard++;
        end
        if (!took)
            chk("send_timeout", guard, 0);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    // Monitor: a code is transferred at the posedge following a negedge with valid && ready.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (reset_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_code", exp_q.size(), 1);
                end else begin
                    mon_exp = exp_q.pop_front();
                    chk("code", int'(code), int'(mon_exp));
                end
            end
        end
    end

    initial begin
        int pat[8];
        pat = '{1, 0, 0, 1, 1, 0, 0, 1};

        reset_n   = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b1;
        in_data   = '0;
        out_ready = 1'b1;

        // Reset held with a valid sample present.
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_code", int'(code), 0);
        chk("rst_overload", overload, 0);
        chk("rst_in_ready", in_ready, 1);
        reset_n  = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_out_valid", out_valid, 0);

        for (int i = 0; i < 4; i++) send(0, 0);
        in_valid = 1'b0;
        @(negedge clk);
        chk("zero_overload", overload, 0);

        // Exact one-LSB input: one code per cycle, error stays zero.
        for (int i = 0; i < 6; i++) send(2048, 1);
        in_valid = 1'b0;
        drain();

        // Reset pulse, then half-LSB input.
        reset_n = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", out_valid, 0);
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) send(1024, pat[i]);

        // Negative full scale lands exactly on QMIN.
        for (int i = 0; i < 8; i++) send(-32768, -16);

        // Positive full scale clamps at QMAX.
        for (int i = 0; i < 4; i++) send(32767, 15);
        in_valid = 1'b0;
        #1;
        chk("ovf_set", overload, 1);
        for (int i = 0; i < 3; i++) send(0, 0);
        in_valid = 1'b0;
        #1;
        chk("ovf_sticky", overload, 1);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        #1;
        chk("clr_overload", overload, 0);
        chk("clr_out_valid", out_valid, 0);
        @(negedge clk);

        // Backpressure: consumer stalls 5 cycles mid-stream.
        fork
            begin
                for (int i = 0; i < 8; i++) send(1024, pat[i]);
                in_valid = 1'b0;
            end
            begin
                repeat (4) @(negedge clk);
                out_ready = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    #1;
                    chk("stall_in_ready", in_ready, 0);
                    chk("stall_out_valid", out_valid, 1);
                    chk("stall_code", int'(code), 1);
                    @(negedge clk);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Clear coinciding with an accept drops the sample and the error history.
        send(1024, 1);
        in_data  = sample_t'(12345);
        in_valid = 1'b1;
        clear    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clear    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("clr_acc_out_valid", out_valid, 0);
        chk("clr_acc_code", int'(code), 0);
        @(negedge clk);
        send(2048, 1);
        in_valid = 1'b0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
